fp_addsub_seq: RTL

//  Multi-cycle floating-point adder/subtractor for the Zuse-style arithmetic unit.

---
 rtl/fp_addsub_seq.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/fp_addsub_seq.sv
// Multi-cycle floating-point adder/subtractor: load/swap, serial align, add, normalise.
// Optional round-to-nearest-even stage enabled by the FP_ROUND_EN macro.
module fp_addsub_seq #(
   parameter int unsigned EW = 7,
   parameter int unsigned MW = 14
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          sub,
   input  logic          a_sign,
   input  logic [EW-1:0] a_exp,
   input  logic [MW-1:0] a_mant,
   input  logic          b_sign,
   input  logic [EW-1:0] b_exp,
   input  logic [MW-1:0] b_mant,
   output logic          busy,
   output logic          done,
   output logic          r_sign,
   output logic [EW-1:0] r_exp,
   output logic [MW-1:0] r_mant,
   output logic          ovf,
   output logic          unf
);

   localparam int unsigned XW = MW + 4;
   localparam int unsigned SW = MW + 5;
   localparam int unsigned EX = EW + 1;
   localparam int unsigned DW = $clog2(MW + 4);
   localparam logic [EW-1:0]        ZEXP  = {1'b1, {(EW-1){1'b0}}};
   localparam logic [EW-1:0]        EMAXE = {1'b0, {(EW-1){1'b1}}};
   localparam logic signed [EX-1:0] EMAX  = {2'b00, {(EW-1){1'b1}}};
   localparam logic signed [EX-1:0] EMIN  = {2'b11, {(EW-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
   } state_t;

   state_t                 r_state;
   logic                   r_as, r_bs, r_xs, r_ys;
   logic [EW-1:0]          r_ae, r_be;
   logic [MW-1:0]          r_am, r_bm;
   logic [XW-1:0]          r_xm, r_ym;
   logic signed [EX-1:0]   r_xe, r_e;
   logic [DW-1:0]          r_d;
   logic [SW-1:0]          r_m;

   logic                   w_az, w_bz, w_swap;
   logic [XW-1:0]          w_axm, w_bxm;
   logic signed [EX-1:0]   w_aex, w_bex, w_ne;
   logic [EX-1:0]          w_diff;
   logic [DW-1:0]          w_dcap;
   logic [SW-1:0]          w_sum, w_nm;
   logic                   w_normd, w_zero, w_fin, w_ovf, w_unf, w_fs;
   logic [EW-1:0]          w_fe;
   logic [MW-1:0]          w_fm;
`ifdef FP_ROUND_EN
   logic                   w_rup;
   logic [MW+1:0]          w_rs;
`endif

   // Operand preparation, working-value update and result formatting
   always_comb begin
      w_az   = (r_ae == ZEXP);
      w_bz   = (r_be == ZEXP);
      w_axm  = w_az ? '0 : {1'b1, r_am, 3'b000};
      w_bxm  = w_bz ? '0 : {1'b1, r_bm, 3'b000};
      w_aex  = {r_ae[EW-1], r_ae};
      w_bex  = {r_be[EW-1], r_be};
      w_swap = (w_bex > w_aex) || ((w_bex == w_aex) && (w_bxm > w_axm));
      w_diff = w_swap ? EX'(w_bex - w_aex) : EX'(w_aex - w_bex);
      if (w_az || w_bz)
         w_dcap = '0;
      else if (w_diff > EX'(MW + 3))
         w_dcap = DW'(MW + 3);
      else
         w_dcap = DW'(w_diff);

      w_sum = (r_xs == r_ys) ? ({1'b0, r_xm} + {1'b0, r_ym})
                             : ({1'b0, r_xm} - {1'b0, r_ym});

      w_nm = r_m;
      w_ne = r_e;
`ifdef FP_ROUND_EN
      w_rup = r_m[2] & (r_m[1] | r_m[0] | r_m[3]);
      w_rs  = {1'b0, r_m[SW-2:3]} + (MW+2)'(w_rup);
`endif
      case (r_state)
         S_ADD: begin
            w_nm = w_sum;
            w_ne = r_xe;
         end
         S_NORM: begin
            if (r_m[SW-1]) begin
               w_nm = {1'b0, r_m[SW-1:2], r_m[1] | r_m[0]};
               w_ne = r_e + EX'(1);
            end else begin
               w_nm = {r_m[SW-2:0], 1'b0};
               w_ne = r_e - EX'(1);
            end
         end
`ifdef FP_ROUND_EN
         // A rounding carry yields 10.00..0, renormalised here
         S_ROUND: begin
            if (w_rs[MW+1]) begin
               w_nm = {1'b0, w_rs[MW+1:1], 3'b000};
               w_ne = r_e + EX'(1);
            end else begin
               w_nm = {1'b0, w_rs[MW:0], 3'b000};
            end
         end
`endif
         default: ;
      endcase

      w_normd = ~w_nm[SW-1] & w_nm[SW-2];
      w_zero  = (r_state == S_ADD) && (w_sum == '0);
`ifdef FP_ROUND_EN
      w_fin   = w_zero || (r_state == S_ROUND);
`else
      w_fin   = w_zero || (((r_state == S_ADD) || (r_state == S_NORM)) && w_normd);
`endif

      w_ovf = 1'b0;
      w_unf = 1'b0;
      w_fs  = r_xs;
      w_fe  = w_ne[EW-1:0];
      w_fm  = w_nm[SW-3:3];
      if (w_zero) begin
         w_fs = 1'b0;
         w_fe = ZEXP;
         w_fm = '0;
      end else if (w_ne > EMAX) begin
         w_ovf = 1'b1;
         w_fe  = EMAXE;
         w_fm  = '1;
      end else if (w_ne <= EMIN) begin
         w_unf = 1'b1;
         w_fs  = 1'b0;
         w_fe  = ZEXP;
         w_fm  = '0;
      end
   end

   // Sequencer, datapath registers and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_as    <= 1'b0;
         r_bs    <= 1'b0;
         r_ae    <= '0;
         r_be    <= '0;
         r_am    <= '0;
         r_bm    <= '0;
         r_xs    <= 1'b0;
         r_ys    <= 1'b0;
         r_xm    <= '0;
         r_ym    <= '0;
         r_xe    <= '0;
         r_e     <= '0;
         r_d     <= '0;
         r_m     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         r_sign  <= 1'b0;
         r_exp   <= '0;
         r_mant  <= '0;
         ovf     <= 1'b0;
         unf     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_as    <= a_sign;
                  r_ae    <= a_exp;
                  r_am    <= a_mant;
                  r_bs    <= b_sign ^ sub;
                  r_be    <= b_exp;
                  r_bm    <= b_mant;
                  busy    <= 1'b1;
                  r_state <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (w_swap) begin
                  r_xs <= r_bs;
                  r_xe <= w_bex;
                  r_xm <= w_bxm;
                  r_ys <= r_as;
                  r_ym <= w_axm;
               end else begin
                  r_xs <= r_as;
                  r_xe <= w_aex;
                  r_xm <= w_axm;
                  r_ys <= r_bs;
                  r_ym <= w_bxm;
               end
               r_d     <= w_dcap;
               r_state <= (w_dcap == '0) ? S_ADD : S_ALIGN;
            end
            S_ALIGN: begin
               r_ym <= {1'b0, r_ym[XW-1:2], r_ym[1] | r_ym[0]};
               r_d  <= r_d - DW'(1);
               if (r_d == DW'(1))
                  r_state <= S_ADD;
            end
            S_ADD, S_NORM: begin
               r_m <= w_nm;
               r_e <= w_ne;
`ifdef FP_ROUND_EN
               r_state <= w_normd ? S_ROUND : S_NORM;
`else
               r_state <= S_NORM;
`endif
            end
            S_DONE: begin
               done    <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase

         // Completion overrides the transition chosen above
         if (w_fin) begin
            r_sign  <= w_fs;
            r_exp   <= w_fe;
            r_mant  <= w_fm;
            ovf     <= w_ovf;
            unf     <= w_unf;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_DONE;
         end
      end
   end

endmodule
